// File: rtl/lupa_spi_pkg.sv
// Frame format shared by both ends of the LUPA configuration SPI link.
package lupa_spi_pkg;

    localparam int ADDR_W_DEF  = 7;
    localparam int DATA_W_DEF  = 9;
    localparam int FRAME_W_DEF = ADDR_W_DEF + DATA_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } spi_rx_state_e;

    // Address field: the bits sent first, so they sit at the top of the frame.
    function automatic logic [ADDR_W_DEF-1:0] frame_addr(input logic [FRAME_W_DEF-1:0] frame);
        return frame[FRAME_W_DEF-1 -: ADDR_W_DEF];
    endfunction

    // Data field: the bits sent last, at the bottom of the frame.
    function automatic logic [DATA_W_DEF-1:0] frame_data(input logic [FRAME_W_DEF-1:0] frame);
        return frame[DATA_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/lupa_sync_edge.sv
// Two-flop synchroniser for one asynchronous level, plus registered edge pulses.
module lupa_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q, rise_q, fall_q;
    logic meta_d, sync_d, prev_d, rise_d, fall_d;

    // Next values: shift the chain, compare the synced level with its previous value.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    // Synchroniser and edge-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/lupa_spi_rx.sv
// Sensor-side SPI receiver: deserialises address+data frames, checks their
// length, mirrors accepted writes into a shadow bank and counts them.
module lupa_spi_rx
    import lupa_spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clock_40,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_en,
    input  logic              spi_dat,
    input  logic [3:0]        nrg,
    output logic              rx_valid,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              cfg_rx_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W + 2);

    logic clk_rise, clk_sync_unused, clk_fall_unused;
    logic en_sync, en_rise, en_fall;

    lupa_sync_edge u_clk_sync (
        .clk     (clock_40),
        .reset   (reset),
        .async_i (spi_clk),
        .sync_o  (clk_sync_unused),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall_unused)
    );

    lupa_sync_edge u_en_sync (
        .clk     (clock_40),
        .reset   (reset),
        .async_i (spi_en),
        .sync_o  (en_sync),
        .rise_o  (en_rise),
        .fall_o  (en_fall)
    );

    spi_rx_state_e      state_q, state_d;
    logic [2:0]         dat_sync_q, dat_sync_d;
    logic [1:0]         warm_q, warm_d;
    logic               seen_low_q, seen_low_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]   bits_q, bits_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]  rx_addr_q, rx_addr_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               cfg_rx_done_q, cfg_rx_done_d;
    logic [DATA_W-1:0]  rd_data_q;
    logic               wr_en;
    logic               start_ok;

    logic [DATA_W-1:0]  bank_mem [2**ADDR_W];

    // A start is only trusted once spi_en has been seen low after the
    // synchroniser has filled; this drops the tail of a frame cut by reset.
    assign start_ok = en_rise & seen_low_q;

    // Frame FSM, bit accounting and accept/reject decision.
    always_comb begin
        state_d       = state_q;
        dat_sync_d    = {dat_sync_q[1:0], spi_dat};
        warm_d        = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        seen_low_d    = seen_low_q | ((warm_q == 2'd3) & ~en_sync);
        shift_d       = shift_q;
        bits_d        = bits_q;
        rx_valid_d    = 1'b0;
        frame_err_d   = 1'b0;
        rx_addr_d     = rx_addr_q;
        rx_data_d     = rx_data_q;
        frame_cnt_d   = frame_cnt_q;
        wr_en         = 1'b0;
        cfg_rx_done_d = cfg_rx_done_q |
                        ((nrg != 4'd0) && (frame_cnt_q == CNT_W'(nrg)));

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    bits_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (en_fall) begin
                    // Decision is taken here so the result pulses during CHECK.
                    state_d = ST_CHECK;
                    if (bits_q == BIT_W'(FRAME_W)) begin
                        rx_valid_d  = 1'b1;
                        rx_addr_d   = shift_q[FRAME_W-1 -: ADDR_W];
                        rx_data_d   = shift_q[DATA_W-1:0];
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        wr_en       = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (clk_rise) begin
                    shift_d = {shift_q[FRAME_W-2:0], dat_sync_q[2]};
                    if (bits_q != BIT_W'(FRAME_W + 1)) begin
                        bits_d = bits_q + BIT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (start_ok) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    bits_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_40) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dat_sync_q    <= '0;
            warm_q        <= '0;
            seen_low_q    <= 1'b0;
            shift_q       <= '0;
            bits_q        <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            rx_addr_q     <= '0;
            rx_data_q     <= '0;
            frame_cnt_q   <= '0;
            cfg_rx_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dat_sync_q    <= dat_sync_d;
            warm_q        <= warm_d;
            seen_low_q    <= seen_low_d;
            shift_q       <= shift_d;
            bits_q        <= bits_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            rx_addr_q     <= rx_addr_d;
            rx_data_q     <= rx_data_d;
            frame_cnt_q   <= frame_cnt_d;
            cfg_rx_done_q <= cfg_rx_done_d;
        end
    end

    // Shadow bank write port; contents survive reset.
    always_ff @(posedge clock_40) begin
        if (wr_en) begin
            bank_mem[rx_addr_d] <= rx_data_d;
        end
    end

    // Registered readback; a same-cycle write is seen on the following read.
    always_ff @(posedge clock_40) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= bank_mem[rd_addr];
        end
    end

    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign rx_addr     = rx_addr_q;
    assign rx_data     = rx_data_q;
    assign frame_cnt   = frame_cnt_q;
    assign cfg_rx_done = cfg_rx_done_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_lupa_spi_rx.sv
// Bench for lupa_spi_rx: directed SPI frames, scoreboard of expected results,
// independent monitor comparing every rx_valid / frame_err pulse.
module tb_lupa_spi_rx;

    logic       clock_40 = 1'b0;
    logic       reset    = 1'b1;
    logic       spi_clk  = 1'b0;
    logic       spi_en   = 1'b0;
    logic       spi_dat  = 1'b0;
    logic [3:0] nrg      = 4'd0;
    logic       rx_valid;
    logic [6:0] rx_addr;
    logic [8:0] rx_data;
    logic       frame_err;
    logic [7:0] frame_cnt;
    logic       cfg_rx_done;
    logic [6:0] rd_addr  = 7'd0;
    logic [8:0] rd_data;

    lupa_spi_rx dut (
        .clock_40    (clock_40),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_en      (spi_en),
        .spi_dat     (spi_dat),
        .nrg         (nrg),
        .rx_valid    (rx_valid),
        .rx_addr     (rx_addr),
        .rx_data     (rx_data),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt),
        .cfg_rx_done (cfg_rx_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clock_40 = ~clock_40;

    typedef struct {
        bit         is_err;
        logic [6:0] addr;
        logic [8:0] data;
        logic [7:0] cnt;
        bit         done;
        bit         done_next;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] model_cnt = 8'd0;
    bit         model_done = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h, required %h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic push_ok(input logic [6:0] a, input logic [8:0] d);
        exp_t e;
        model_cnt   = model_cnt + 8'd1;
        e.is_err    = 1'b0;
        e.addr      = a;
        e.data      = d;
        e.cnt       = model_cnt;
        e.done      = model_done;
        model_done  = model_done | ((nrg != 4'd0) && (model_cnt == {4'd0, nrg}));
        e.done_next = model_done;
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err    = 1'b1;
        e.addr      = 7'd0;
        e.data      = 9'd0;
        e.cnt       = model_cnt;
        e.done      = model_done;
        e.done_next = model_done;
        sb_q.push_back(e);
    endtask

    task automatic clock_bits(input int nbits, input logic [63:0] val);
        for (int i = 0; i < nbits; i++) begin
            spi_dat = val[nbits-1-i];
            repeat (4) @(negedge clock_40);
            spi_clk = 1'b1;
            repeat (4) @(negedge clock_40);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [63:0] val, input int gap);
        spi_en = 1'b1;
        repeat (4) @(negedge clock_40);
        clock_bits(nbits, val);
        repeat (4) @(negedge clock_40);
        spi_en = 1'b0;
        repeat (gap) @(negedge clock_40);
    endtask

    task automatic send_ok(input logic [6:0] a, input logic [8:0] d, input int gap);
        push_ok(a, d);
        send_frame(16, {48'd0, a, d}, gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clock_40);
        repeat (3) @(negedge clock_40);
        check("drain_pending", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock_40);
        reset = 1'b1;
        repeat (2) @(negedge clock_40);
        reset      = 1'b0;
        model_cnt  = 8'd0;
        model_done = 1'b0;
    endtask

    task automatic rd_check(input logic [6:0] a, input logic [8:0] d);
        @(negedge clock_40);
        rd_addr = a;
        @(negedge clock_40);
        check($sformatf("rd_data[%h]", a), rd_data, d);
    endtask

    // Monitor: every output pulse is matched against the oldest expectation.
    always @(negedge clock_40) begin
        if (!reset && (rx_valid || frame_err)) begin
            $display("event: valid=%0b err=%0b addr=%h data=%h cnt=%0d done=%0b",
                     rx_valid, frame_err, rx_addr, rx_data, frame_cnt, cfg_rx_done);
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b, required none",
                         rx_valid, frame_err);
            end else begin
                mon_e = sb_q.pop_front();
                check("kind", {30'd0, rx_valid, frame_err}, mon_e.is_err ? 32'd1 : 32'd2);
                check("frame_cnt", frame_cnt, mon_e.cnt);
                check("cfg_rx_done", cfg_rx_done, mon_e.done);
                if (!mon_e.is_err) begin
                    check("rx_addr", rx_addr, mon_e.addr);
                    check("rx_data", rx_data, mon_e.data);
                    @(negedge clock_40);
                    check("cfg_rx_done_next", cfg_rx_done, mon_e.done_next);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock_40);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rx_addr", rx_addr, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_cfg_rx_done", cfg_rx_done, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        repeat (10) @(negedge clock_40);

        // Single good frame and readback
        send_ok(7'h05, 9'h1A3, 8);
        drain();
        check("cnt_after_one", frame_cnt, 1);
        rd_check(7'h05, 9'h1A3);

        // Short, long and very long frames are rejected; bank untouched
        push_err();
        send_frame(15, 64'h2AAA, 8);
        push_err();
        send_frame(17, {47'd0, 1'b1, 7'h05, 9'h0AA}, 8);
        push_err();
        send_frame(48, 64'h0000_1234_5678_0BA3, 8);
        drain();
        check("cnt_after_errs", frame_cnt, 1);
        rd_check(7'h05, 9'h1A3);

        // Back-to-back frames with a 2-cycle spi_en gap
        send_ok(7'h10, 9'h0FF, 2);
        send_ok(7'h11, 9'h100, 8);
        drain();
        check("cnt_after_b2b", frame_cnt, 3);
        rd_check(7'h10, 9'h0FF);
        rd_check(7'h11, 9'h100);

        // Reset in the middle of a frame with spi_en held high
        spi_en = 1'b1;
        repeat (4) @(negedge clock_40);
        clock_bits(7, 64'h05);
        do_reset();
        clock_bits(9, 64'h1A3);
        repeat (4) @(negedge clock_40);
        spi_en = 1'b0;
        repeat (12) @(negedge clock_40);
        check("cnt_after_cut", frame_cnt, 0);
        check("done_after_rst_nrg0", cfg_rx_done, 0);
        send_ok(7'h7F, 9'h1FF, 8);
        drain();
        check("cnt_after_recover", frame_cnt, 1);
        rd_check(7'h7F, 9'h1FF);

        // nrg == 0 never raises cfg_rx_done
        for (int i = 0; i < 3; i++) send_ok(7'h40 + 7'(i), 9'h055 + 9'(i), 8);
        drain();
        check("cnt_nrg0", frame_cnt, 4);
        check("done_nrg0", cfg_rx_done, 0);

        // Eight frames against nrg = 8; done is sticky when nrg is raised
        do_reset();
        nrg = 4'd8;
        repeat (10) @(negedge clock_40);
        for (int i = 0; i < 8; i++) send_ok(7'h20 + 7'(i), 9'h100 + 9'(3 * i), 8);
        drain();
        check("cnt_nrg8", frame_cnt, 8);
        check("done_nrg8", cfg_rx_done, 1);
        nrg = 4'd15;
        repeat (5) @(negedge clock_40);
        check("done_sticky", cfg_rx_done, 1);
        rd_check(7'h27, 9'h115);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
